seq_word_serializer: RTL and testbench

SEQ_WORD_SERIALIZER -- requirements
Module: seq_word_serializer

---
 rtl/seq_word_serializer_pkg.sv | 22 ++
 rtl/seq_word_serializer_word_fifo.sv | 79 +++++++
 rtl/seq_word_serializer.sv | 132 +++++++++++++
 tb/tb_seq_word_serializer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_word_serializer_pkg.sv
// ============================================================================
// Module   : seq_word_serializer_pkg
// Brief    : Shared state encoding and default sizes for the word serializer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package seq_word_serializer_pkg;

    localparam int c_default_width = 7;
    localparam int c_default_depth = 2;
    localparam int c_idx_w         = 3;
    localparam int c_count_w       = 4;

    typedef logic [0:0] ser_state_t;

    localparam ser_state_t c_st_idle  = 1'b0;
    localparam ser_state_t c_st_shift = 1'b1;

endpackage

`default_nettype wire

// File: rtl/seq_word_serializer_word_fifo.sv
// ============================================================================
// Module   : word_fifo
// Brief    : Small word buffer with wrap-around pointers and registered ready.
// Revision : 1.0
// ============================================================================
`default_nettype none

module word_fifo
    import seq_word_serializer_pkg::*;
#(
    parameter int WIDTH = c_default_width,
    parameter int DEPTH = c_default_depth
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic [WIDTH-1:0]     push_data,
    input  logic                 pop,
    output logic [WIDTH-1:0]     pop_data,
    output logic [c_count_w-1:0] count,
    output logic                 can_push
);

    localparam int                   c_ptr_w = $clog2(DEPTH);
    localparam logic [c_count_w-1:0] c_depth = c_count_w'(DEPTH);

    logic [WIDTH-1:0]     r_mem [DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_count_w-1:0] r_count;
    logic [c_count_w-1:0] w_count_next;
    logic                 r_can_push;
    logic                 w_push_ok;
    logic                 w_pop_ok;

    always_comb begin
        w_push_ok    = push && r_can_push && !reset;
        w_pop_ok     = pop && (r_count != '0);
        w_count_next = r_count;
        case ({w_push_ok, w_pop_ok})
            2'b10:   w_count_next = r_count + c_count_w'(1);
            2'b01:   w_count_next = r_count - c_count_w'(1);
            default: w_count_next = r_count;
        endcase
    end

    // Storage is not reset; contents are only ever read behind a valid count.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_can_push <= 1'b1;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            r_count    <= w_count_next;
            // Ready tracks the updated occupancy, so a pop frees space one cycle later.
            r_can_push <= (w_count_next < c_depth);
        end
    end

    assign pop_data = r_mem[r_rd_ptr];
    assign count    = r_count;
    assign can_push = r_can_push;

endmodule

`default_nettype wire

// File: rtl/seq_word_serializer.sv
// ============================================================================
// Module   : seq_word_serializer
// Brief    : Buffers parallel words and shifts them out MSB first, one bit/clk.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seq_word_serializer
    import seq_word_serializer_pkg::*;
#(
    parameter int WIDTH = c_default_width,
    parameter int DEPTH = c_default_depth
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     in_word,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 bit_out,
    output logic                 bit_valid,
    output logic [c_idx_w-1:0]   bit_idx,
    output logic                 word_start,
    output logic                 word_last,
    output logic [c_count_w-1:0] count
);

    localparam logic [c_idx_w-1:0] c_idx_prelast = c_idx_w'(WIDTH - 2);

    ser_state_t           r_state;
    ser_state_t           w_state_next;
    logic                 w_load;
    logic                 w_bit_valid;
    logic                 w_buf_nonempty;
    logic [WIDTH-1:0]     w_head;
    logic [WIDTH-1:0]     r_shift;
    logic                 r_bit_out;
    logic [c_idx_w-1:0]   r_bit_idx;
    logic                 r_word_start;
    logic                 r_word_last;
    logic [c_count_w-1:0] w_count;
    logic                 w_in_ready;

    word_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_word_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (in_valid),
        .push_data (in_word),
        .pop       (w_load),
        .pop_data  (w_head),
        .count     (w_count),
        .can_push  (w_in_ready)
    );

    assign w_buf_nonempty = (w_count != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_buf_nonempty) begin
                    w_state_next = c_st_shift;
                end
            end
            c_st_shift: begin
                if (r_word_last && !w_buf_nonempty) begin
                    w_state_next = c_st_idle;
                end
            end
            default: w_state_next = c_st_idle;
        endcase
    end

    // A buffered word is taken either from idle or right behind the last bit.
    always_comb begin
        w_bit_valid = (r_state == c_st_shift);
        w_load      = 1'b0;
        if (w_buf_nonempty) begin
            w_load = (r_state == c_st_idle) || ((r_state == c_st_shift) && r_word_last);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift      <= '0;
            r_bit_out    <= 1'b0;
            r_bit_idx    <= '0;
            r_word_start <= 1'b0;
            r_word_last  <= 1'b0;
        end else if (w_load) begin
            r_shift      <= {w_head[WIDTH-2:0], 1'b0};
            r_bit_out    <= w_head[WIDTH-1];
            r_bit_idx    <= '0;
            r_word_start <= 1'b1;
            r_word_last  <= 1'b0;
        end else if ((r_state == c_st_shift) && !r_word_last) begin
            r_shift      <= {r_shift[WIDTH-2:0], 1'b0};
            r_bit_out    <= r_shift[WIDTH-1];
            r_bit_idx    <= r_bit_idx + c_idx_w'(1);
            r_word_start <= 1'b0;
            r_word_last  <= (r_bit_idx == c_idx_prelast);
        end else if (r_state == c_st_shift) begin
            // Last bit with nothing queued: park the outputs while idle.
            r_shift      <= '0;
            r_bit_out    <= 1'b0;
            r_bit_idx    <= '0;
            r_word_start <= 1'b0;
            r_word_last  <= 1'b0;
        end
    end

    assign in_ready   = w_in_ready;
    assign count      = w_count;
    assign bit_valid  = w_bit_valid;
    assign bit_out    = r_bit_out;
    assign bit_idx    = r_bit_idx;
    assign word_start = r_word_start;
    assign word_last  = r_word_last;

endmodule

`default_nettype wire

// File: tb/tb_seq_word_serializer.sv
// ============================================================================
// Module   : tb_seq_word_serializer
// Brief    : Scoreboard bench for the word serializer (directed vectors).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_seq_word_serializer;

    localparam int W = 7;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] in_word = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         bit_out;
    logic         bit_valid;
    logic [2:0]   bit_idx;
    logic         word_start;
    logic         word_last;
    logic [3:0]   count;

    typedef struct packed {
        logic       b;
        logic [2:0] idx;
        logic       st;
        logic       la;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    seq_word_serializer #(
        .WIDTH (W),
        .DEPTH (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_word    (in_word),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .bit_out    (bit_out),
        .bit_valid  (bit_valid),
        .bit_idx    (bit_idx),
        .word_start (word_start),
        .word_last  (word_last),
        .count      (count)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no summary expected completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // MSB-first expansion of a word into its seven expected serial records.
    function automatic void expect_word(input logic [W-1:0] w);
        exp_t e;
        for (int i = 0; i < W; i++) begin
            e.b   = w[W-1-i];
            e.idx = 3'(i);
            e.st  = (i == 0);
            e.la  = (i == W - 1);
            exp_q.push_back(e);
        end
    endfunction

    // Monitor: every valid bit must match the head of the expected queue.
    always @(negedge clk) begin
        exp_t e;
        exp_t act;
        if (bit_valid === 1'b1) begin
            act = {bit_out, bit_idx, word_start, word_last};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL serial_bit: got unexpected bit=%0b idx=%0d expected no valid bit", bit_out, bit_idx);
            end else begin
                e = exp_q.pop_front();
                if (act !== e) begin
                    n_fail++;
                    $display("FAIL serial_bit: got {bit,idx,start,last}=%0b,%0d,%0b,%0b expected %0b,%0d,%0b,%0b",
                             act.b, act.idx, act.st, act.la, e.b, e.idx, e.st, e.la);
                end
            end
        end
    end

    // Offer one word for one cycle; called back-to-back it holds in_valid high.
    task automatic offer(input logic [W-1:0] w, input logic exp_ready, input logic to_sb);
        in_valid = 1'b1;
        in_word  = w;
        check("in_ready_at_offer", 32'(in_ready), 32'(exp_ready));
        if (exp_ready && to_sb) expect_word(w);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 64; i++) begin
            if (exp_q.size() == 0 && bit_valid === 1'b0) break;
            @(posedge clk); #1;
        end
        check(name, 32'(exp_q.size() == 0 && bit_valid === 1'b0), 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"},   32'(in_ready),   32'd1);
        check({tag, "_bit_valid"},  32'(bit_valid),  32'd0);
        check({tag, "_bit_out"},    32'(bit_out),    32'd0);
        check({tag, "_bit_idx"},    32'(bit_idx),    32'd0);
        check({tag, "_word_start"}, 32'(word_start), 32'd0);
        check({tag, "_word_last"},  32'(word_last),  32'd0);
        check({tag, "_count"},      32'(count),      32'd0);
    endtask

    task automatic check_silent(input string name, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            if (bit_valid !== 1'b0) seen++;
            @(posedge clk); #1;
        end
        check(name, 32'(seen), 32'd0);
    endtask

    initial begin
        logic t1_bits [7];
        exp_t e;
        int   run;
        bit   found;

        t1_bits = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

        // Reset state
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        reset = 1'b0;

        // Single word 0010100, hand-listed bit stream
        for (int i = 0; i < 7; i++) begin
            e.b   = t1_bits[i];
            e.idx = 3'(i);
            e.st  = (i == 0);
            e.la  = (i == 6);
            exp_q.push_back(e);
        end
        offer(7'b0010100, 1'b1, 1'b0);
        check("lat_idle_after_accept", 32'(bit_valid), 32'd0);
        check("lat_count_after_accept", 32'(count), 32'd1);
        @(posedge clk); #1;
        check("lat_valid_next_edge", 32'(bit_valid), 32'd1);
        check("lat_first_idx", 32'(bit_idx), 32'd0);
        wait_drain("single_word_drain");

        // Back-to-back words: 14 contiguous bits
        offer(7'b1111111, 1'b1, 1'b1);
        offer(7'b0000001, 1'b1, 1'b1);
        run = 0;
        for (int i = 0; i < 20; i++) begin
            if (bit_valid !== 1'b1) break;
            run++;
            @(posedge clk); #1;
        end
        check("b2b_contiguous_bits", 32'(run), 32'd14);
        wait_drain("b2b_drain");

        // Continuous offers: buffer fills at two, later offers dropped
        offer(7'h11, 1'b1, 1'b1);
        offer(7'h22, 1'b1, 1'b1);
        offer(7'h33, 1'b1, 1'b1);
        check("full_count", 32'(count), 32'd2);
        offer(7'h44, 1'b0, 1'b1);
        offer(7'h55, 1'b0, 1'b1);
        wait_drain("full_drain");

        // Push exactly on word_last with one word queued
        offer(7'b1100110, 1'b1, 1'b1);
        offer(7'b0101011, 1'b1, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (word_last === 1'b1) begin
                found = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check("last_push_reached_word_last", 32'(found), 32'd1);
        in_valid = 1'b1;
        in_word  = 7'b1000011;
        check("last_push_ready", 32'(in_ready), 32'd1);
        expect_word(7'b1000011);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("last_push_count_held", 32'(count), 32'd1);
        check("last_push_next_start", 32'(word_start), 32'd1);
        check("last_push_next_idx", 32'(bit_idx), 32'd0);
        wait_drain("last_push_drain");

        // Reset at bit_idx 3 of 1010101 with one word buffered
        offer(7'b1010101, 1'b1, 1'b1);
        offer(7'b0110011, 1'b1, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bit_valid === 1'b1 && bit_idx === 3'd3) begin
                found = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check("midword_reached_idx3", 32'(found), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        exp_q.delete();
        check_reset_values("midword_reset");
        reset = 1'b0;
        check_silent("midword_no_resume", 20);

        // Offer while reset is asserted is ignored
        reset    = 1'b1;
        in_valid = 1'b1;
        in_word  = 7'b1111111;
        @(posedge clk); #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        check("reset_offer_count", 32'(count), 32'd0);
        check_silent("reset_offer_no_bits", 16);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
